// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instruction and operands, patches
// operands with the same-cycle writeback, and inserts load-use bubbles.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic        id_uses_rt,
   input  logic [31:0] id_rdata1,
   input  logic [31:0] id_rdata2,
   input  logic [31:0] id_imm,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        id_mem_to_reg,
   input  logic        id_alu_src,
   input  logic [3:0]  id_alu_op,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rw,
   input  logic [31:0] wb_wdata,
   input  logic        ex_flush,
   input  logic        mem_hold,
   output logic        stall,
   output logic        ex_valid,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_rd,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [31:0] ex_imm,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_mem_to_reg,
   output logic        ex_alu_src,
   output logic [3:0]  ex_alu_op,
   output logic [15:0] bubble_cnt
);

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        alu_src;
      logic [3:0]  alu_op;
   } ex_t;

   typedef enum logic [1:0] {
      ACT_LOAD   = 2'd0,
      ACT_FLUSH  = 2'd1,
      ACT_HOLD   = 2'd2,
      ACT_BUBBLE = 2'd3
   } act_e;

   // Register file writes on the edge, so a same-cycle write must be patched in here.
   function automatic logic [31:0] wb_bypass(
      input logic [4:0]  idx,
      input logic [31:0] rdata,
      input logic        we,
      input logic [4:0]  rw,
      input logic [31:0] wdata
   );
      if (we && (rw != 5'd0) && (rw == idx)) begin
         return wdata;
      end else begin
         return rdata;
      end
   endfunction

   ex_t         ex_r;
   ex_t         ex_nxt_s;
   ex_t         id_pkt_s;
   act_e        act_s;
   logic        hz_s;
   logic [31:0] a_in_s;
   logic [31:0] b_in_s;
   logic [15:0] bubble_cnt_r;

   // Operand bypass from writeback
   always_comb begin
      a_in_s = wb_bypass(id_rs, id_rdata1, wb_reg_write, wb_rw, wb_wdata);
      b_in_s = wb_bypass(id_rt, id_rdata2, wb_reg_write, wb_rw, wb_wdata);
   end

   // Load-use hazard detection and per-edge action selection
   always_comb begin
      hz_s = id_valid && ex_r.valid && ex_r.mem_read && (ex_r.rd != 5'd0) &&
             ((ex_r.rd == id_rs) || (id_uses_rt && (ex_r.rd == id_rt)));
      if (ex_flush) begin
         act_s = ACT_FLUSH;
      end else if (mem_hold) begin
         act_s = ACT_HOLD;
      end else if (hz_s) begin
         act_s = ACT_BUBBLE;
      end else begin
         act_s = ACT_LOAD;
      end
   end

   // Packet an ID instruction becomes in EX; invalid slots carry no controls
   always_comb begin
      id_pkt_s.valid = id_valid;
      id_pkt_s.rs    = id_rs;
      id_pkt_s.rt    = id_rt;
      id_pkt_s.rd    = id_rd;
      id_pkt_s.a     = a_in_s;
      id_pkt_s.b     = b_in_s;
      id_pkt_s.imm   = id_imm;
      if (id_valid) begin
         id_pkt_s.reg_write  = id_reg_write;
         id_pkt_s.mem_read   = id_mem_read;
         id_pkt_s.mem_write  = id_mem_write;
         id_pkt_s.mem_to_reg = id_mem_to_reg;
         id_pkt_s.alu_src    = id_alu_src;
         id_pkt_s.alu_op     = id_alu_op;
      end else begin
         id_pkt_s.reg_write  = 1'b0;
         id_pkt_s.mem_read   = 1'b0;
         id_pkt_s.mem_write  = 1'b0;
         id_pkt_s.mem_to_reg = 1'b0;
         id_pkt_s.alu_src    = 1'b0;
         id_pkt_s.alu_op     = 4'd0;
      end
   end

   // Next EX contents; bubbles are all-zero so they never match hazard compares
   always_comb begin
      ex_nxt_s = ex_r;
      case (act_s)
         ACT_FLUSH:  ex_nxt_s = '0;
         ACT_HOLD:   ex_nxt_s = ex_r;
         ACT_BUBBLE: ex_nxt_s = '0;
         ACT_LOAD:   ex_nxt_s = id_pkt_s;
         default:    ex_nxt_s = '0;
      endcase
   end

   // EX pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_r <= '0;
      end else begin
         ex_r <= ex_nxt_s;
      end
   end

   // Saturating load-use bubble counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_r <= 16'd0;
      end else if ((act_s == ACT_BUBBLE) && (bubble_cnt_r != 16'hFFFF)) begin
         bubble_cnt_r <= bubble_cnt_r + 16'd1;
      end else begin
         bubble_cnt_r <= bubble_cnt_r;
      end
   end

   assign stall         = !ex_flush && (hz_s || mem_hold);
   assign ex_valid      = ex_r.valid;
   assign ex_rs         = ex_r.rs;
   assign ex_rt         = ex_r.rt;
   assign ex_rd         = ex_r.rd;
   assign ex_a          = ex_r.a;
   assign ex_b          = ex_r.b;
   assign ex_imm        = ex_r.imm;
   assign ex_reg_write  = ex_r.reg_write;
   assign ex_mem_read   = ex_r.mem_read;
   assign ex_mem_write  = ex_r.mem_write;
   assign ex_mem_to_reg = ex_r.mem_to_reg;
   assign ex_alu_src    = ex_r.alu_src;
   assign ex_alu_op     = ex_r.alu_op;
   assign bubble_cnt    = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand sequences
// for reset/saturation, and randomized traffic against a rule-level model.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rt;
   logic [31:0] id_rdata1, id_rdata2, id_imm;
   logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
   logic [3:0]  id_alu_op;
   logic        wb_reg_write;
   logic [4:0]  wb_rw;
   logic [31:0] wb_wdata;
   logic        ex_flush, mem_hold;
   logic        stall, ex_valid;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_a, ex_b, ex_imm;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
   logic [3:0]  ex_alu_op;
   logic [15:0] bubble_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
      .id_alu_op(id_alu_op), .wb_reg_write(wb_reg_write), .wb_rw(wb_rw), .wb_wdata(wb_wdata),
      .ex_flush(ex_flush), .mem_hold(mem_hold), .stall(stall), .ex_valid(ex_valid),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
      .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        v;
      logic [4:0]  rs, rt, rd;
      logic        ur;
      logic [31:0] r1;
      logic        mr;
      logic        we;
      logic [4:0]  rw;
      logic [31:0] wd;
      logic        fl, hd;
      logic        e_stall, e_valid;
      logic [31:0] e_a;
      logic        e_mr;
      logic [15:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(
      input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic ur, input logic [31:0] r1, input logic mr, input logic we,
      input logic [4:0] rw, input logic [31:0] wd, input logic fl, input logic hd,
      input logic es, input logic ev, input logic [31:0] ea, input logic emr,
      input logic [15:0] ecnt);
      vec_t x;
      x.v = v; x.rs = rs; x.rt = rt; x.rd = rd; x.ur = ur; x.r1 = r1; x.mr = mr;
      x.we = we; x.rw = rw; x.wd = wd; x.fl = fl; x.hd = hd;
      x.e_stall = es; x.e_valid = ev; x.e_a = ea; x.e_mr = emr; x.e_cnt = ecnt;
      return x;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_rd = x.rd; id_uses_rt = x.ur;
      id_rdata1 = x.r1; id_rdata2 = ~x.r1; id_imm = {27'd0, x.rd};
      id_reg_write = 1'b1; id_mem_read = x.mr; id_mem_write = 1'b0;
      id_mem_to_reg = x.mr; id_alu_src = x.mr; id_alu_op = 4'd2;
      wb_reg_write = x.we; wb_rw = x.rw; wb_wdata = x.wd;
      ex_flush = x.fl; mem_hold = x.hd;
   endtask

   task automatic run_vec(input vec_t x, input string tag);
      @(negedge clk);
      drive(x);
      #1 chk({tag, "_stall"}, {127'd0, stall}, {127'd0, x.e_stall});
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, {127'd0, ex_valid}, {127'd0, x.e_valid});
      chk({tag, "_a"}, {96'd0, ex_a}, {96'd0, x.e_a});
      chk({tag, "_memrd"}, {127'd0, ex_mem_read}, {127'd0, x.e_mr});
      chk({tag, "_cnt"}, {112'd0, bubble_cnt}, {112'd0, x.e_cnt});
   endtask

   // Rule-level reference of the EX slot
   typedef struct packed {
      logic        valid;
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b, imm;
      logic        rw, mr, mw, m2r, asrc;
      logic [3:0]  op;
   } mdl_t;

   function automatic logic [31:0] byp(input logic [4:0] idx, input logic [31:0] rd_val);
      return (wb_reg_write && wb_rw != 5'd0 && wb_rw == idx) ? wb_wdata : rd_val;
   endfunction

   vec_t tbl[$];
   vec_t seq[$];
   mdl_t m;
   logic [15:0] m_cnt;

   initial begin
      drive(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
               1'b0, 1'b0, 32'd0, 1'b0, 16'd0));
      rst_n = 1'b0;
      #12;
      chk("reset_valid", {127'd0, ex_valid}, 128'd0);
      chk("reset_ab", {64'd0, ex_a, ex_b}, 128'd0);
      chk("reset_cnt", {112'd0, bubble_cnt}, 128'd0);
      chk("reset_stall", {127'd0, stall}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //               v     rs     rt     rd     ur    r1            mr    we    rw     wd            fl    hd    es    ev    ea            emr   cnt
      tbl.push_back(mk(1'b1, 5'd5,  5'd6,  5'd7,  1'b0, 32'h11111111, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0));
      tbl.push_back(mk(1'b1, 5'd5,  5'd6,  5'd7,  1'b0, 32'h11111111, 1'b0, 1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 16'd0));
      tbl.push_back(mk(1'b1, 5'd1,  5'd2,  5'd8,  1'b0, 32'h0000000A, 1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000A, 1'b1, 16'd0));
      tbl.push_back(mk(1'b1, 5'd8,  5'd3,  5'd4,  1'b1, 32'h0000000B, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 16'd1));
      tbl.push_back(mk(1'b1, 5'd8,  5'd3,  5'd4,  1'b1, 32'h0000000B, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000B, 1'b0, 16'd1));
      tbl.push_back(mk(1'b1, 5'd0,  5'd0,  5'd9,  1'b0, 32'h0000000C, 1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000C, 1'b1, 16'd1));
      tbl.push_back(mk(1'b1, 5'd1,  5'd9,  5'd3,  1'b0, 32'h0000000D, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000D, 1'b0, 16'd1));
      tbl.push_back(mk(1'b1, 5'd0,  5'd0,  5'd9,  1'b0, 32'h0000000E, 1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000E, 1'b1, 16'd1));
      tbl.push_back(mk(1'b1, 5'd1,  5'd9,  5'd3,  1'b1, 32'h0000000F, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 16'd2));
      tbl.push_back(mk(1'b1, 5'd1,  5'd9,  5'd3,  1'b1, 32'h0000000F, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000F, 1'b0, 16'd2));
      tbl.push_back(mk(1'b1, 5'd0,  5'd0,  5'd10, 1'b0, 32'h00000010, 1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h00000010, 1'b1, 16'd2));
      tbl.push_back(mk(1'b1, 5'd10, 5'd0,  5'd3,  1'b0, 32'h00000011, 1'b0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 16'd2));
      tbl.push_back(mk(1'b1, 5'd0,  5'd0,  5'd10, 1'b0, 32'h00000012, 1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h00000012, 1'b1, 16'd2));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1'b1, 5'd10, 5'd0, 5'd3, 1'b0, 32'h00000013, 1'b0, 1'b1, 5'd10, 32'hCAFE0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000012, 1'b1, 16'd2));
      tbl.push_back(mk(1'b1, 5'd10, 5'd0,  5'd3,  1'b0, 32'h00000013, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 16'd3));
      tbl.push_back(mk(1'b1, 5'd10, 5'd0,  5'd3,  1'b0, 32'h00000013, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h00000013, 1'b0, 16'd3));
      tbl.push_back(mk(1'b0, 5'd5,  5'd0,  5'd3,  1'b0, 32'h00000014, 1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h00000014, 1'b0, 16'd3));
      tbl.push_back(mk(1'b1, 5'd0,  5'd0,  5'd8,  1'b0, 32'h00000015, 1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h00000015, 1'b1, 16'd3));
      tbl.push_back(mk(1'b0, 5'd8,  5'd0,  5'd3,  1'b0, 32'h00000016, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h00000016, 1'b0, 16'd3));
      tbl.push_back(mk(1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 32'h00000017, 1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h00000017, 1'b1, 16'd3));
      tbl.push_back(mk(1'b1, 5'd0,  5'd0,  5'd3,  1'b0, 32'h00000018, 1'b0, 1'b1, 5'd0,  32'h00000BAD, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000018, 1'b0, 16'd3));
      foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // Mid-stream asynchronous reset between edges
      run_vec(mk(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 32'h00000020, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
                 1'b0, 1'b1, 32'h00000020, 1'b1, 16'd3), "pre_rst");
      @(negedge clk);
      drive(mk(1'b1, 5'd8, 5'd0, 5'd3, 1'b0, 32'h00000021, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0,
               1'b0, 1'b0, 32'd0, 1'b0, 16'd0));
      #1 chk("midrst_stall_before", {127'd0, stall}, {127'd0, 1'b1});
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {127'd0, ex_valid}, 128'd0);
      chk("midrst_a_rd", {91'd0, ex_a, ex_rd}, 128'd0);
      chk("midrst_cnt", {112'd0, bubble_cnt}, 128'd0);
      chk("midrst_stall", {127'd0, stall}, 128'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("midrst_first_load", {96'd0, ex_a}, {96'd0, 32'h00000021});

      // Saturation: preset the counter just below the ceiling
      @(negedge clk);
      force dut.bubble_cnt_r = 16'hFFFE;
      #1 release dut.bubble_cnt_r;
      #1 chk("sat_preset", {112'd0, bubble_cnt}, {112'd0, 16'hFFFE});
      seq.push_back(mk(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 32'h30, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30, 1'b1, 16'hFFFE));
      seq.push_back(mk(1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 32'h31, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 16'hFFFF));
      seq.push_back(mk(1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 32'h31, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h31, 1'b1, 16'hFFFF));
      seq.push_back(mk(1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 32'h32, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 16'hFFFF));
      seq.push_back(mk(1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 32'h32, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h32, 1'b1, 16'hFFFF));
      foreach (seq[i]) run_vec(seq[i], $sformatf("sat%0d", i));

      // Randomized traffic against the reference model
      @(negedge clk);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      m = '0;
      m_cnt = 16'd0;
      for (int c = 0; c < 600; c++) begin
         logic [31:0] a_in, b_in;
         logic hz, exp_stall;
         @(negedge clk);
         id_valid = ($urandom_range(0, 7) != 0);
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         id_rd = 5'($urandom_range(0, 3)); id_uses_rt = 1'($urandom);
         id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
         id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 1) == 0);
         id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
         id_alu_src = 1'($urandom); id_alu_op = 4'($urandom);
         wb_reg_write = 1'($urandom); wb_rw = 5'($urandom_range(0, 3)); wb_wdata = $urandom;
         ex_flush = ($urandom_range(0, 7) == 0); mem_hold = ($urandom_range(0, 5) == 0);
         a_in = byp(id_rs, id_rdata1);
         b_in = byp(id_rt, id_rdata2);
         hz = id_valid && m.valid && m.mr && m.rd != 5'd0 &&
              (m.rd == id_rs || (id_uses_rt && m.rd == id_rt));
         exp_stall = !ex_flush && (hz || mem_hold);
         #1 chk($sformatf("rnd%0d_stall", c), {127'd0, stall}, {127'd0, exp_stall});
         if (ex_flush) m = '0;
         else if (mem_hold) m = m;
         else if (hz) begin
            m = '0;
            m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
         end else begin
            m = '{id_valid, id_rs, id_rt, id_rd, a_in, b_in, id_imm,
                  id_valid & id_reg_write, id_valid & id_mem_read, id_valid & id_mem_write,
                  id_valid & id_mem_to_reg, id_valid & id_alu_src,
                  id_valid ? id_alu_op : 4'd0};
         end
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d_ex", c),
             {7'd0, ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, ex_reg_write,
              ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op},
             {7'd0, m});
         chk($sformatf("rnd%0d_cnt", c), {112'd0, bubble_cnt}, {112'd0, m_cnt});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 5-stage MIPS core, sitting directly downstream of the register file. Each cycle it captures the decoded instruction and the two register-file read operands. It patches those operands with the same-cycle writeback value, since the register file writes on the clock edge while reading combinationally. It also detects load-use hazards and inserts bubbles, and applies branch flushes and downstream holds.

## Interface
Parameters:
- none (data width fixed at 32, register index at 5)

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5  source register indices (same values driving register-file rs/rt)
- id_rd  in  5  destination register index (already muxed rt/rd/31 by decode)
- id_uses_rt  in  1  instruction reads rt as an operand
- id_rdata1, id_rdata2  in  32  register-file read data
- id_imm  in  32  sign/zero-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  in  1 each  decode controls
- id_alu_op  in  4  ALU operation
- wb_reg_write  in  1  writeback enable (same signal as register-file RegWrite)
- wb_rw  in  5  writeback index
- wb_wdata  in  32  writeback data
- ex_flush  in  1  branch/jump taken; squash the instruction entering EX
- mem_hold  in  1  downstream stage busy; freeze EX
- stall  out  1  combinational; freezes PC and IF/ID
- ex_valid  out  1  registered
- ex_rs, ex_rt, ex_rd  out  5  registered
- ex_a, ex_b, ex_imm  out  32  registered
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1  registered
- ex_alu_op  out  4  registered
- bubble_cnt  out  16  saturating count of load-use bubbles inserted

## Operation
- WB bypass:
  - a_in = wb_wdata when wb_reg_write && wb_rw!=0 && wb_rw==id_rs; otherwise a_in = id_rdata1.
  - b_in uses the same rule against id_rt and id_rdata2.
  - No bypass for index 0.
- Load-use hazard, hz:
  - hz = id_valid && ex_valid && ex_mem_read && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
- stall = !ex_flush && (hz || mem_hold).
- Per-edge action, in priority order:
  1. ex_flush: load a bubble.
  2. mem_hold: hold all ex_* registers unchanged.
  3. hz: load a bubble; bubble_cnt += 1, saturating at 0xFFFF.
  4. Otherwise: load the ID contents, with ex_valid = id_valid, ex_a = a_in, ex_b = b_in.
- Bubble: ex_valid = 0 and all control outputs 0. ex_a, ex_b, ex_imm, ex_rs, ex_rt and ex_rd are also 0, so a bubble can never match a hazard or forward compare.
- Controls of an invalid ID instruction (id_valid=0) are loaded as 0 regardless of the decode values.
- During a hold, ID re-reads the register file each cycle. Bypass is evaluated only on the load edge.

## Timing
- Reset (rst_n low, asynchronous): every registered output is 0, including bubble_cnt. stall is therefore 0 because ex_valid=0. Release is synchronous to the next posedge; the first edge after release performs a normal load.
- Reset asserted mid-operation clears EX immediately, independent of clk.
- Latency: ID values appear on ex_* one cycle after the load edge.
- stall is purely combinational from current inputs and ex_* state; it has no registered delay.
- A load-use stall lasts exactly one cycle: after the bubble, ex_valid=0, so hz drops.
- Simultaneous events:
  - hz with ex_flush: flush wins; no bubble is counted; stall=0.
  - hz with mem_hold: hold wins; the counter is unchanged; stall=1.
  - WB bypass with a load in EX: both are evaluated independently.
- bubble_cnt stays at 0xFFFF once reached.

## Test plan
- Reset mid-stream: load an instruction, then pulse rst_n low between edges -> all ex_* and bubble_cnt read 0 before the next posedge; stall=0.
- Same-cycle bypass: id_rs=5, id_rdata1=0x11111111, wb_reg_write=1, wb_rw=5, wb_wdata=0xDEADBEEF -> next cycle ex_a=0xDEADBEEF. Repeat with wb_rw=0 -> ex_a=0x11111111.
- Load-use: EX holds lw with ex_rd=8; ID has id_rs=8 -> stall=1 for one cycle, then ex_valid=0 and bubble_cnt=1; the following cycle the ID instruction loads and stall=0.
- rt-only hazard: ex_rd=9, id_rt=9 -> stall=1 with id_uses_rt=1 and stall=0 with id_uses_rt=0.
- Flush priority: hz and ex_flush both high -> stall=0, bubble loaded, bubble_cnt unchanged.
- Hold then saturation: mem_hold=1 for 3 cycles -> ex_* stable and stall=1. Separately, force bubble_cnt to 0xFFFF via 65535 hazards -> one more hazard leaves it at 0xFFFF.
